// File: rtl/if_id_buffer.sv
// Fetch-to-decode queue: circular FIFO of {instr, pc, pc+4} with valid/ready on both sides.
// A full queue deasserts in_ready, which stalls the PC unit; flush empties the queue.
module if_id_buffer #(
   parameter int unsigned DEPTH     = 2,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
   input  logic                         clk,
   input  logic                         ReSet_n,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [31:0]                  in_instr,
   input  logic [31:0]                  in_pc,
   input  logic [31:0]                  in_pc_plus4,
   input  logic                         flush,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [31:0]                  out_instr,
   output logic [31:0]                  out_pc,
   output logic [31:0]                  out_pc_plus4,
   output logic [$clog2(DEPTH):0]       count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [31:0]      mem_instr_q    [DEPTH];
   logic [31:0]      mem_pc_q       [DEPTH];
   logic [31:0]      mem_pc_plus4_q [DEPTH];

   logic [PTR_W-1:0] wptr_q, wptr_d;
   logic [PTR_W-1:0] rptr_q, rptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [31:0]      out_instr_q, out_instr_d;
   logic [31:0]      out_pc_q, out_pc_d;
   logic [31:0]      out_pc_plus4_q, out_pc_plus4_d;

   logic             push, pop, push_en, pop_en;

   assign in_ready     = (count_q != CNT_W'(DEPTH));
   assign out_valid    = (count_q != '0);
   assign out_instr    = out_valid ? out_instr_q : NOP_INSTR;
   assign out_pc       = out_pc_q;
   assign out_pc_plus4 = out_pc_plus4_q;
   assign count        = count_q;

   always_comb begin
      push    = in_valid & in_ready;
      pop     = out_valid & out_ready;
      push_en = push & ~flush;
      pop_en  = pop & ~flush;

      wptr_d         = wptr_q;
      rptr_d         = rptr_q;
      count_d        = count_q;
      out_instr_d    = out_instr_q;
      out_pc_d       = out_pc_q;
      out_pc_plus4_d = out_pc_plus4_q;

      if (flush) begin
         wptr_d  = '0;
         rptr_d  = '0;
         count_d = '0;
      end else begin
         if (push_en) wptr_d = wptr_q + 1'b1;
         if (pop_en)  rptr_d = rptr_q + 1'b1;
         if (push_en && !pop_en)      count_d = count_q + 1'b1;
         else if (!push_en && pop_en) count_d = count_q - 1'b1;
      end

      // Head registers track the next-cycle head; the entry being pushed this
      // cycle is not in mem yet, so take it straight from the inputs.
      if (count_d != '0) begin
         if (push_en && (wptr_q == rptr_d)) begin
            out_instr_d    = in_instr;
            out_pc_d       = in_pc;
            out_pc_plus4_d = in_pc_plus4;
         end else begin
            out_instr_d    = mem_instr_q[rptr_d];
            out_pc_d       = mem_pc_q[rptr_d];
            out_pc_plus4_d = mem_pc_plus4_q[rptr_d];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push_en) begin
         mem_instr_q[wptr_q]    <= in_instr;
         mem_pc_q[wptr_q]       <= in_pc;
         mem_pc_plus4_q[wptr_q] <= in_pc_plus4;
      end
   end

   always_ff @(posedge clk or negedge ReSet_n) begin
      if (!ReSet_n) begin
         wptr_q         <= '0;
         rptr_q         <= '0;
         count_q        <= '0;
         out_instr_q    <= '0;
         out_pc_q       <= '0;
         out_pc_plus4_q <= '0;
      end else begin
         wptr_q         <= wptr_d;
         rptr_q         <= rptr_d;
         count_q        <= count_d;
         out_instr_q    <= out_instr_d;
         out_pc_q       <= out_pc_d;
         out_pc_plus4_q <= out_pc_plus4_d;
      end
   end

endmodule

// File: tb/tb_if_id_buffer.sv
// Directed bench for if_id_buffer (DEPTH=2): reset, fill/stall, drain, streaming, flush, async reset.
module tb_if_id_buffer;

   logic        clk = 1'b0;
   logic        ReSet_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_instr;
   logic [31:0] in_pc;
   logic [31:0] in_pc_plus4;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [31:0] out_pc;
   logic [31:0] out_pc_plus4;
   logic [1:0]  count;

   int unsigned checks   = 0;
   int unsigned failures = 0;

   if_id_buffer #(.DEPTH(2), .NOP_INSTR(32'h0000_0000)) dut (
      .clk          (clk),
      .ReSet_n      (ReSet_n),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_instr     (in_instr),
      .in_pc        (in_pc),
      .in_pc_plus4  (in_pc_plus4),
      .flush        (flush),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_instr    (out_instr),
      .out_pc       (out_pc),
      .out_pc_plus4 (out_pc_plus4),
      .count        (count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
      end
   endtask

   // Instruction word is derived from the PC so each entry is distinguishable.
   task automatic offer(input logic [31:0] pc);
      in_pc       = pc;
      in_pc_plus4 = pc + 32'd4;
      in_instr    = 32'hA500_0000 ^ pc;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      ReSet_n   = 1'b0;
      in_valid  = 1'b1;
      out_ready = 1'b0;
      flush     = 1'b0;
      offer(32'h3000);

      // T1 reset held with in_valid asserted
      step();
      step();
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_count",     {30'd0, count},     32'd0);
      check("rst_out_instr", out_instr,          32'h0);
      check("rst_out_pc",    out_pc,             32'h0);
      check("rst_out_pc4",   out_pc_plus4,       32'h0);
      in_valid = 1'b0;
      ReSet_n  = 1'b1;
      step();
      check("rst_in_ready",  {31'd0, in_ready},  32'd1);
      check("rst_count_rel", {30'd0, count},     32'd0);

      // T2 fill and stall
      in_valid = 1'b1;
      offer(32'h3000);
      step();
      check("fill1_count",     {30'd0, count},     32'd1);
      check("fill1_out_valid", {31'd0, out_valid}, 32'd1);
      check("fill1_out_pc",    out_pc,             32'h3000);
      offer(32'h3004);
      step();
      check("fill2_count",     {30'd0, count},     32'd2);
      check("fill2_in_ready",  {31'd0, in_ready},  32'd0);
      check("fill2_out_pc",    out_pc,             32'h3000);
      check("fill2_out_pc4",   out_pc_plus4,       32'h3004);
      check("fill2_out_instr", out_instr,          32'hA500_3000);
      offer(32'h3008);
      step();
      check("full_push_count", {30'd0, count},     32'd2);
      check("full_push_pc",    out_pc,             32'h3000);

      // T3 drain
      in_valid  = 1'b0;
      out_ready = 1'b1;
      step();
      check("drain1_count",    {30'd0, count},     32'd1);
      check("drain1_out_pc",   out_pc,             32'h3004);
      check("drain1_instr",    out_instr,          32'hA500_3004);
      check("drain1_in_ready", {31'd0, in_ready},  32'd1);
      step();
      check("drain2_count",    {30'd0, count},     32'd0);
      check("drain2_valid",    {31'd0, out_valid}, 32'd0);
      check("drain2_instr",    out_instr,          32'h0);
      check("drain2_pc_hold",  out_pc,             32'h3004);
      step();
      check("empty_pop_count", {30'd0, count},     32'd0);

      // T4 streaming push+pop every cycle, pointers wrap several times
      in_valid  = 1'b1;
      out_ready = 1'b1;
      for (int k = 0; k <= 8; k++) begin
         offer(32'h3000 + 32'(4 * k));
         step();
         check("stream_count", {30'd0, count}, 32'd1);
         check("stream_pc",    out_pc,         32'h3000 + 32'(4 * k));
         check("stream_instr", out_instr,      32'hA500_0000 ^ (32'h3000 + 32'(4 * k)));
      end
      in_valid = 1'b0;
      step();
      check("stream_end_count", {30'd0, count}, 32'd0);

      // T5 flush with a full queue and a pending push
      out_ready = 1'b0;
      in_valid  = 1'b1;
      offer(32'h3030);
      step();
      offer(32'h3034);
      step();
      check("pre_flush_count", {30'd0, count}, 32'd2);
      flush = 1'b1;
      offer(32'h3040);
      step();
      check("flush_count", {30'd0, count},     32'd0);
      check("flush_valid", {31'd0, out_valid}, 32'd0);
      check("flush_instr", out_instr,          32'h0);
      flush = 1'b0;
      offer(32'h3080);
      step();
      check("post_flush_count", {30'd0, count}, 32'd1);
      check("post_flush_pc",    out_pc,         32'h3080);
      // flush beats a simultaneous push and pop
      out_ready = 1'b1;
      flush     = 1'b1;
      offer(32'h3084);
      step();
      check("flush2_count", {30'd0, count}, 32'd0);
      flush    = 1'b0;
      in_valid = 1'b0;
      step();
      check("flush2_not_queued", {30'd0, count}, 32'd0);

      // T6 asynchronous reset between clock edges
      out_ready = 1'b0;
      in_valid  = 1'b1;
      offer(32'h30C0);
      step();
      check("t6_count_pre", {30'd0, count},     32'd1);
      check("t6_valid_pre", {31'd0, out_valid}, 32'd1);
      in_valid = 1'b0;
      #3;
      ReSet_n = 1'b0;
      #1;
      check("t6_async_valid", {31'd0, out_valid}, 32'd0);
      check("t6_async_count", {30'd0, count},     32'd0);
      check("t6_async_pc",    out_pc,             32'h0);
      check("t6_async_instr", out_instr,          32'h0);
      #2;
      ReSet_n = 1'b1;
      step();
      check("t6_in_ready", {31'd0, in_ready}, 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
